prog_feeder: RTL and testbench
==============================

PROG_FEEDER -- requirements
Module: prog_feeder

Interface
REQ-001 Parameter DEPTH, default 32, number of 16-bit program words (power of two).
REQ-002 Parameter TIMEOUT, default 15, max cycles waiting for Done before error.
REQ-003 Clock  input  1  single clock; all state updates on rising edge.
REQ-004 Resetn  input  1  synchronous, active-high reset; Resetn=1 at a rising edge resets the block.
REQ-005 Start  input  1  single-cycle request to run the program from address 0.
REQ-006 WrEn  input  1  program-store write strobe, honoured only in IDLE or HALT.
REQ-007 WrAddr  input  log2(DEPTH)  program-store write address.
REQ-008 WrData  input  16  program-store write data.
REQ-009 Done  input  1  processor instruction-complete strobe.
REQ-010 DIN  output  16  word presented to the processor data input.
REQ-011 Run  output  1  one-cycle instruction-issue strobe to the processor.
REQ-012 PC  output  log2(DEPTH)  address of the next word to fetch.
REQ-013 Busy  output  1  high in every state except IDLE and HALT.
REQ-014 Halted  output  1  high in HALT.
REQ-015 Error  output  1  sticky Done-timeout flag.

Function
REQ-016 Opcode field is DIN[15:13]; 3'b001 = mvi (next word is its immediate); 3'b111 = halt; all others are single-word instructions.
REQ-017 Program store is DEPTH x 16 synchronous-read memory; read data is valid one cycle after address.
REQ-018 States: IDLE, FETCH, ISSUE, IMM, WAIT, HALT.
REQ-019 IDLE/HALT + Start -> FETCH with PC=0 and Error cleared; Start ignored in all other states.
REQ-020 FETCH: memory addressed at PC; next cycle -> ISSUE.
REQ-021 ISSUE: DIN=fetched word; Run=1 for exactly this cycle unless opcode is halt; PC<=PC+1.
REQ-022 ISSUE with halt opcode: Run stays 0 and the next state is HALT.
REQ-023 ISSUE with mvi -> IMM; otherwise -> WAIT.
REQ-024 IMM: DIN=word at the incremented PC (read issued during ISSUE), held one cycle; PC<=PC+1; -> WAIT.
REQ-025 WAIT: DIN holds its last value; Done=1 -> FETCH; Done during ISSUE or IMM is ignored.
REQ-026 WAIT timeout counter starts at 0 on entry; if TIMEOUT cycles elapse without Done: Error<=1 and state -> HALT.
REQ-027 PC wraps from DEPTH-1 to 0, including an mvi at address DEPTH-1 whose immediate comes from address 0.
REQ-028 Write with WrEn in IDLE/HALT updates the store next edge; WrEn in any other state is dropped.
REQ-029 Done and timeout expiry in the same cycle: Done wins; no Error.
REQ-030 Run is never high in two consecutive cycles.

Reset
REQ-031 Reset forces IDLE; PC=0, DIN=0, Run=0, Busy=0, Halted=0, Error=0, timeout counter=0.
REQ-032 Reset mid-program aborts immediately with no further Run pulse; program store contents are preserved.
REQ-033 Reset takes priority over Start, WrEn and Done in the same cycle.

Structure
REQ-034 Shared package holds opcode constants (OP_MVI, OP_HALT), the state enumeration, and the 16-bit word width.
REQ-035 One sub-module, prog_mem: synchronous-read, single-write DEPTH x 16 RAM; the FSM, PC and timeout logic live in prog_feeder.

Verification
REQ-036 Load {0x0000, 0xE000}, Start, Done 2 cycles after Run -> one Run with DIN=0x0000, then Halted=1, PC=2, Error=0.
REQ-037 Load {0x2000, 0x1234, 0xE000}, Start -> Run with DIN=0x2000, next cycle DIN=0x1234 with Run=0, then after Done halt at PC=3.
REQ-038 Load {0x0000, ...}, never assert Done -> Error=1 and Halted=1 exactly TIMEOUT cycles after entering WAIT, with no second Run.
REQ-039 DEPTH=32, word 31=0x2000, word 0=0xABCD, PC driven to 31 -> immediate DIN=0xABCD and PC wraps to 1.
REQ-040 Assert Resetn in WAIT, then Start without reloading -> identical Run/DIN sequence replays; WrEn pulsed while Busy leaves memory unchanged.

Source files
------------

// File: rtl/prog_feeder_pkg.sv
// prog_feeder_pkg: shared definitions for the program feeder.
//   WORD_W  - program word / processor data width
//   OP_MVI  - opcode whose following word is an immediate operand
//   OP_HALT - opcode that stops the feeder without issuing
//   state_t - feeder FSM states
//   opcode  - extracts the opcode field from a program word
package prog_feeder_pkg;

  localparam int WORD_W = 16;

  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_IMM,
    ST_WAIT,
    ST_HALT
  } state_t;

  function automatic logic [2:0] opcode(input logic [WORD_W-1:0] w);
    return w[WORD_W-1:WORD_W-3];
  endfunction

endpackage

// File: rtl/prog_feeder_mem.sv
// prog_mem: DEPTH x WORD_W single-write, synchronous-read program store.
// Contents are never reset so a program survives a feeder reset.
// Ports:
//   i_clk   - clock
//   i_we    - write enable (already qualified by the feeder)
//   i_waddr - write address
//   i_wdata - write data
//   i_raddr - read address, data appears on o_rdata after the next edge
//   o_rdata - registered read data
module prog_mem
  import prog_feeder_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/prog_feeder.sv
// prog_feeder: steps through a stored program, presenting each word to a
// processor and pulsing Run per instruction, then waiting for Done.
// Ports:
//   Clock  - clock, all state on the rising edge
//   Resetn - synchronous active-high reset (store contents preserved)
//   Start  - run the program from address 0 (honoured in IDLE/HALT)
//   WrEn   - program-store write strobe (honoured in IDLE/HALT)
//   WrAddr - program-store write address
//   WrData - program-store write data
//   Done   - processor instruction-complete strobe
//   DIN    - word presented to the processor
//   Run    - one-cycle instruction-issue strobe
//   PC     - address of the next word to fetch
//   Busy   - high outside IDLE and HALT
//   Halted - high in HALT
//   Error  - sticky Done-timeout flag, cleared by Start
module prog_feeder
  import prog_feeder_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 15,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              WrEn,
  input  logic [AW-1:0]     WrAddr,
  input  logic [WORD_W-1:0] WrData,
  input  logic              Done,
  output logic [WORD_W-1:0] DIN,
  output logic              Run,
  output logic [AW-1:0]     PC,
  output logic              Busy,
  output logic              Halted,
  output logic              Error
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            r_state;
  logic [AW-1:0]     r_pc;
  logic [WORD_W-1:0] r_din;
  logic [TW-1:0]     r_tcnt;
  logic              r_err;

  logic [WORD_W-1:0] w_rdata;
  logic [AW-1:0]     w_raddr;
  logic              w_we;
  logic              w_idle_or_halt;
  logic              w_halt_op;
  logic              w_mvi_op;

  assign w_idle_or_halt = (r_state == ST_IDLE) || (r_state == ST_HALT);
  // Reset wins over a coincident write.
  assign w_we      = WrEn && !Resetn && w_idle_or_halt;
  // During ISSUE the store is already addressed at PC+1 so a possible
  // immediate word is ready in IMM; the AW-bit add wraps DEPTH-1 to 0.
  assign w_raddr   = (r_state == ST_ISSUE) ? r_pc + AW'(1) : r_pc;
  assign w_halt_op = (opcode(w_rdata) == OP_HALT);
  assign w_mvi_op  = (opcode(w_rdata) == OP_MVI);

  prog_mem #(.DEPTH(DEPTH)) u_mem (
    .i_clk   (Clock),
    .i_we    (w_we),
    .i_waddr (WrAddr),
    .i_wdata (WrData),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge Clock) begin
    if (Resetn) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_din   <= '0;
      r_tcnt  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALT: begin
          if (Start) begin
            r_state <= ST_FETCH;
            r_pc    <= '0;
            r_err   <= 1'b0;
          end
        end
        ST_FETCH: r_state <= ST_ISSUE;
        ST_ISSUE: begin
          r_din  <= w_rdata;
          r_pc   <= r_pc + AW'(1);
          r_tcnt <= '0;
          if (w_halt_op)     r_state <= ST_HALT;
          else if (w_mvi_op) r_state <= ST_IMM;
          else               r_state <= ST_WAIT;
        end
        ST_IMM: begin
          r_din   <= w_rdata;
          r_pc    <= r_pc + AW'(1);
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Done has priority over a timeout expiring in the same cycle.
          if (Done) begin
            r_state <= ST_FETCH;
          end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= ST_HALT;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The store output is itself a register, so ISSUE/IMM present it
  // directly; other states hold the last presented word.
  assign DIN    = ((r_state == ST_ISSUE) || (r_state == ST_IMM)) ? w_rdata : r_din;
  assign Run    = (r_state == ST_ISSUE) && !w_halt_op;
  assign PC     = r_pc;
  assign Busy   = !w_idle_or_halt;
  assign Halted = (r_state == ST_HALT);
  assign Error  = r_err;

endmodule

// File: tb/tb_prog_feeder.sv
module tb_prog_feeder;
  localparam int DEPTH   = 32;
  localparam int TIMEOUT = 15;
  localparam int AW      = $clog2(DEPTH);

  logic          clk;
  logic          Resetn, Start, WrEn, Done;
  logic [AW-1:0] WrAddr;
  logic [15:0]   WrData;
  logic [15:0]   DIN;
  logic          Run, Busy, Halted, Error;
  logic [AW-1:0] PC;

  int total = 0;
  int bad   = 0;
  int resp_left = 0;
  bit mon_en = 0;
  logic [15:0] exp_q[$];

  prog_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .Clock(clk), .Resetn(Resetn), .Start(Start), .WrEn(WrEn),
    .WrAddr(WrAddr), .WrData(WrData), .Done(Done), .DIN(DIN),
    .Run(Run), .PC(PC), .Busy(Busy), .Halted(Halted), .Error(Error)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic we_too);
    @(negedge clk);
    Resetn = 1; WrEn = we_too; WrAddr = AW'(2); WrData = 16'hFFFF;
    @(negedge clk);
    Resetn = 0; WrEn = 0;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    @(negedge clk);
    WrEn = 1; WrAddr = AW'(a); WrData = d;
    @(negedge clk);
    WrEn = 0;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    Start = 1;
    @(negedge clk);
    Start = 0;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!(Halted === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("halt_reached", 32'(Halted), 32'd1);
  endtask

  // Processor model: answers a Run with Done two cycles later.
  initial begin
    Done = 0;
    forever begin
      @(negedge clk);
      if (Run === 1'b1 && resp_left > 0) begin
        resp_left--;
        repeat (2) @(negedge clk);
        Done = 1;
        @(negedge clk);
        Done = 0;
      end
    end
  end

  // Monitor: every Run and every immediate cycle consumes one expectation.
  initial begin
    logic [15:0] e;
    bit prev_run = 0;
    bit prev_mvi = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (Run === 1'b1) begin
          chk("run_consec", 32'(prev_run), 32'd0);
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_run: DIN=%h with nothing expected", DIN);
          end else begin
            e = exp_q.pop_front();
            chk("run_din", 32'(DIN), 32'(e));
          end
        end else if (prev_mvi) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_imm: DIN=%h with nothing expected", DIN);
          end else begin
            e = exp_q.pop_front();
            chk("imm_din", 32'(DIN), 32'(e));
          end
        end
        prev_run = (Run === 1'b1);
        prev_mvi = prev_run && (DIN[15:13] == 3'b001);
      end
    end
  end

  initial begin
    bit seen;
    Resetn = 0; Start = 0; WrEn = 0; WrAddr = '0; WrData = '0;

    // Reset state
    do_reset(1'b0);
    mon_en = 1;
    chk("rst_pc", 32'(PC), 32'd0);
    chk("rst_din", 32'(DIN), 32'd0);
    chk("rst_run", 32'(Run), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_halted", 32'(Halted), 32'd0);
    chk("rst_error", 32'(Error), 32'd0);

    // Single instruction then halt
    wr(0, 16'h0000); wr(1, 16'hE000);
    exp_q.push_back(16'h0000);
    resp_left = 1000;
    start_pulse();
    chk("t1_busy", 32'(Busy), 32'd1);
    wait_halt(200);
    chk("t1_pc", 32'(PC), 32'd2);
    chk("t1_err", 32'(Error), 32'd0);
    chk("t1_busy_off", 32'(Busy), 32'd0);
    chk("t1_q", 32'(exp_q.size()), 32'd0);

    // mvi with immediate, then halt
    wr(0, 16'h2000); wr(1, 16'h1234); wr(2, 16'hE000);
    exp_q.push_back(16'h2000); exp_q.push_back(16'h1234);
    start_pulse();
    wait_halt(200);
    chk("t2_pc", 32'(PC), 32'd3);
    chk("t2_err", 32'(Error), 32'd0);
    chk("t2_q", 32'(exp_q.size()), 32'd0);

    // Done never arrives: timeout exactly TIMEOUT cycles into WAIT
    wr(0, 16'h0000); wr(1, 16'h0000);
    exp_q.push_back(16'h0000);
    resp_left = 0;
    start_pulse();
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (Run === 1'b1) seen = 1;
      else @(negedge clk);
    end
    chk("t3_run_seen", 32'(seen), 32'd1);
    repeat (TIMEOUT) @(negedge clk);
    chk("t3_halted_early", 32'(Halted), 32'd0);
    chk("t3_err_early", 32'(Error), 32'd0);
    @(negedge clk);
    chk("t3_halted", 32'(Halted), 32'd1);
    chk("t3_err", 32'(Error), 32'd1);
    chk("t3_q", 32'(exp_q.size()), 32'd0);

    // mvi at DEPTH-1 takes its immediate from address 0; PC wraps to 1
    wr(0, 16'hABCD);
    for (int a = 1; a < DEPTH - 1; a++) wr(a, 16'h0000);
    wr(DEPTH - 1, 16'h2000);
    exp_q.push_back(16'hABCD);
    for (int a = 1; a < DEPTH - 1; a++) exp_q.push_back(16'h0000);
    exp_q.push_back(16'h2000);
    exp_q.push_back(16'hABCD);
    resp_left = DEPTH - 1;
    start_pulse();
    chk("t4_err_cleared", 32'(Error), 32'd0);
    wait_halt(600);
    chk("t4_pc_wrap", 32'(PC), 32'd1);
    chk("t4_err", 32'(Error), 32'd1);
    chk("t4_q", 32'(exp_q.size()), 32'd0);

    // Reset mid-program, then replay without reloading
    wr(0, 16'h2000); wr(1, 16'h5555); wr(2, 16'h4321); wr(3, 16'hE000);
    exp_q.push_back(16'h2000); exp_q.push_back(16'h5555); exp_q.push_back(16'h4321);
    resp_left = 1;
    start_pulse();
    repeat (8) @(negedge clk);
    chk("t5_busy_wait", 32'(Busy), 32'd1);
    chk("t5_q1", 32'(exp_q.size()), 32'd0);
    do_reset(1'b1);
    chk("t5_rst_busy", 32'(Busy), 32'd0);
    chk("t5_rst_pc", 32'(PC), 32'd0);
    chk("t5_rst_din", 32'(DIN), 32'd0);
    repeat (5) @(negedge clk);
    exp_q.push_back(16'h2000); exp_q.push_back(16'h5555); exp_q.push_back(16'h4321);
    resp_left = 1000;
    start_pulse();
    chk("t5_busy_wr", 32'(Busy), 32'd1);
    wr(2, 16'hFFFF);
    start_pulse();
    wait_halt(200);
    chk("t5_pc", 32'(PC), 32'd4);
    chk("t5_err", 32'(Error), 32'd0);
    chk("t5_q2", 32'(exp_q.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
